knn_host_sequencer: RTL and testbench
=====================================

# knn_host_sequencer

Host-side controller driving the command/data pins of the registered KNN top (clk, reset, wr_en, rd_en, start, done, k, dataValueIn, dataNameOut, dataValueOut). It accepts a job command plus a valid/ready stream of training and query words, frames them into the accelerator's write/start/done sequence, waits out the fixed compute latency, then reads back the k nearest neighbours and returns them on a valid/ready result stream with a last marker.

## Interface
- DATA_WIDTH, 32: width of one data word per channel
- DIMENSIONS, 32: words per vector
- NUM_CH, 1: channels per write beat
- MAX_K, 16: largest accepted k
- RD_LATENCY, 2: cycles from knn_rd_en high to valid knn_dataNameOut/knn_dataValueOut (includes the wrapper's input register)
- COMPUTE_CYCLES, 64: cycles waited after knn_done before the first read
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- cmd_go  in  1  job request, sampled only in IDLE
- cmd_k  in  32  neighbours to return
- cmd_num_train  in  32  training vectors to load before the query vector
- busy  out  1  job in progress
- err  out  1  one-cycle pulse on a rejected command
- in_valid / in_ready  in / out  1 / 1  write-data stream handshake
- in_data  in  NUM_CH*DATA_WIDTH  training words, then query words
- knn_wr_en, knn_rd_en, knn_start, knn_done  out  1 each  accelerator controls
- knn_k  out  32  latched k
- knn_dataValueIn  out  NUM_CH*DATA_WIDTH  registered write data
- knn_dataNameOut  in  32  neighbour index from accelerator
- knn_dataValueOut  in  DATA_WIDTH  neighbour distance from accelerator
- out_valid / out_ready  out / in  1 / 1  result stream handshake
- out_name  out  32; out_value  out  DATA_WIDTH; out_last  out  1 (high on the k-th result)

## Operation
- States: IDLE, START, LOAD, DONE, WAIT, RD_ISSUE, RD_WAIT, RD_OUT.
- IDLE: on cmd_go, if 1 ≤ cmd_k ≤ MAX_K, latch cmd_k into knn_k and cmd_num_train, then go to START. Otherwise pulse err and stay in IDLE.
- START: knn_start high for exactly one cycle, then go to LOAD.
- LOAD: in_ready=1. Each beat with in_valid & in_ready produces, next cycle, knn_wr_en=1 with knn_dataValueIn = that beat. Beat count is tracked by a dimension counter (0..DIMENSIONS-1) and a vector counter (0..num_train); no product is computed, so there is no overflow. After the final query beat, go to DONE.
- DONE: knn_done high for one cycle, computed so it lands the cycle after the final knn_wr_en. Then go to WAIT.
- WAIT: count COMPUTE_CYCLES cycles, then go to RD_ISSUE.
- RD_ISSUE: knn_rd_en high for one cycle. RD_WAIT lasts RD_LATENCY cycles, then name/value are captured into the output registers.
- RD_OUT: out_valid=1, with out_last=1 when result index = k-1. On out_ready, go back to RD_ISSUE, or to IDLE after the k-th result.
- cmd_num_train=0: only the DIMENSIONS query beats are loaded.
- cmd_go while busy: ignored, with no err.
- busy=1 in every state except IDLE.

## Timing
- Reset: every output is 0 and the state is IDLE; knn_k and the counters clear. Asserting reset mid-job aborts immediately, so any partial knn_wr_en train is dropped and the host must restart.
- cmd_go at edge N: knn_start high in cycle N+1; in_ready first high in cycle N+2.
- Write latency is 1 cycle from handshake to knn_wr_en. Back-to-back beats give 1 beat per cycle, and in_valid gaps give gaps in knn_wr_en.
- Per result: 1 (issue) + RD_LATENCY + 1 cycle to out_valid. out_valid/out_name/out_value/out_last stay stable until out_ready.
- Back to IDLE the cycle after the final out handshake; busy falls in that cycle.

## Configuration
- KNN_SEQ_PERF_EN defined: adds output perf_cycles (32-bit). It clears on an accepted cmd_go, increments every busy cycle, saturates at 2^32-1, and holds its value in IDLE.
- Undefined: the port and the counter are absent, and behaviour is otherwise identical.

## Structure
- Shared package knn_pkg holds:
  - the state enum
  - KNN_NAME_W=32 and KNN_K_W=32
  - a default-parameter constant set shared with the accelerator top
- Sub-module knn_rd_capture contains RD_ISSUE/RD_WAIT/RD_OUT: it generates the rd pulse, counts the latency, and holds the output register with the valid/ready handshake. The main FSM hands it a result index and k, and receives a last-done indication back.

## Test plan
- Reset mid-LOAD after 10 beats → all outputs 0 on assertion; a fresh job completes normally afterwards.
- cmd_k=0, and separately cmd_k=MAX_K+1 → err pulses for one cycle, busy stays 0, knn_start never fires.
- DIMENSIONS=4, num_train=2, k=2, continuous in_valid → 12 knn_wr_en cycles, exactly 1 knn_start before them and 1 knn_done the cycle after the last; model returns names 7,3 → out stream 7, 3(last).
- Random in_valid gaps and out_ready back-pressure → knn_wr_en count = (num_train+1)*DIMENSIONS, and result order is preserved.
- cmd_go pulsed during WAIT → no effect; a second job after IDLE runs cleanly.
- With KNN_SEQ_PERF_EN and num_train=0, DIMENSIONS=4, k=1, no stalls → perf_cycles equals the hand-computed cycle count from cmd_go acceptance to return to IDLE.

Source files
------------

// File: rtl/knn_pkg.sv
// Shared constants, default parameter set and sequencer state encoding for the KNN host side.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package knn_pkg;

  localparam int KNN_NAME_W = 32;  // neighbour index width on the accelerator pins
  localparam int KNN_K_W    = 32;  // k width on the accelerator pins

  // Default parameter set, kept identical to the accelerator top's defaults.
  localparam int KNN_DEF_DATA_WIDTH     = 32;
  localparam int KNN_DEF_DIMENSIONS     = 32;
  localparam int KNN_DEF_NUM_CH         = 1;
  localparam int KNN_DEF_MAX_K          = 16;
  localparam int KNN_DEF_RD_LATENCY     = 2;
  localparam int KNN_DEF_COMPUTE_CYCLES = 64;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_LOAD,
    S_DONE,
    S_WAIT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_RD_OUT
  } seq_state_t;

endpackage

// File: rtl/knn_rd_capture.sv
// Read-back stage: pulses knn_rd_en, waits RD_LATENCY cycles, captures one neighbour into an output register.
// Latency: issue -> out_valid is 1 + RD_LATENCY cycles (out_valid appears RD_LATENCY+1 cycles after the issue cycle).
// Backpressure: the output register holds name/value/last stable while out_valid && !out_ready.
// Ports: issue (one-cycle read request), idx/k (result index and job k, for the last flag),
//        knn_rd_en/knn_dataNameOut/knn_dataValueOut (accelerator read pins),
//        out_* (result stream), wait_done/rsp_fire/last_done (status back to the sequencer FSM).
module knn_rd_capture
  import knn_pkg::*;
#(
  parameter int DATA_WIDTH = KNN_DEF_DATA_WIDTH,
  parameter int RD_LATENCY = KNN_DEF_RD_LATENCY
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  issue,
  input  logic [KNN_K_W-1:0]    idx,
  input  logic [KNN_K_W-1:0]    k,
  output logic                  knn_rd_en,
  input  logic [KNN_NAME_W-1:0] knn_dataNameOut,
  input  logic [DATA_WIDTH-1:0] knn_dataValueOut,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [KNN_NAME_W-1:0] out_name,
  output logic [DATA_WIDTH-1:0] out_value,
  output logic                  out_last,
  output logic                  wait_done,
  output logic                  rsp_fire,
  output logic                  last_done
);

  localparam int LAT_W = 8;

  logic             pending_q;
  logic [LAT_W-1:0] lat_q;

  assign knn_rd_en = issue;
  // Last wait cycle: the accelerator's read data is valid on the pins right now.
  assign wait_done = pending_q && (lat_q == LAT_W'(RD_LATENCY - 1));
  assign rsp_fire  = out_valid && out_ready;
  assign last_done = rsp_fire && out_last;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q <= 1'b0;
      lat_q     <= '0;
      out_valid <= 1'b0;
      out_name  <= '0;
      out_value <= '0;
      out_last  <= 1'b0;
    end else begin
      if (issue) begin
        pending_q <= 1'b1;
        lat_q     <= '0;
      end else if (wait_done) begin
        pending_q <= 1'b0;
        out_valid <= 1'b1;
        out_name  <= knn_dataNameOut;
        out_value <= knn_dataValueOut;
        out_last  <= (idx == k - KNN_K_W'(1));
      end else if (pending_q) begin
        lat_q <= lat_q + LAT_W'(1);
      end
      if (rsp_fire) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/knn_host_sequencer.sv
// Host sequencer for the KNN accelerator: job command + write stream in, start/wr/done framing, timed read-back, result stream out.
// Latency: in handshake -> knn_wr_en 1 cycle; knn_done 1 cycle after last knn_wr_en; first read COMPUTE_CYCLES after knn_done.
// Backpressure: in_ready only in LOAD; results held in an output register until out_ready.
// Ports: clk/reset (async active-low); cmd_go/cmd_k/cmd_num_train, busy, err (command side);
//        in_valid/in_ready/in_data (write stream); knn_* (accelerator pins); out_* (result stream).
// Optional build macro KNN_SEQ_PERF_EN adds perf_cycles: busy-cycle count of the last job, saturating.
module knn_host_sequencer
  import knn_pkg::*;
#(
  parameter int DATA_WIDTH     = KNN_DEF_DATA_WIDTH,
  parameter int DIMENSIONS     = KNN_DEF_DIMENSIONS,
  parameter int NUM_CH         = KNN_DEF_NUM_CH,
  parameter int MAX_K          = KNN_DEF_MAX_K,
  parameter int RD_LATENCY     = KNN_DEF_RD_LATENCY,
  parameter int COMPUTE_CYCLES = KNN_DEF_COMPUTE_CYCLES
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_go,
  input  logic [KNN_K_W-1:0]           cmd_k,
  input  logic [31:0]                  cmd_num_train,
  output logic                         busy,
  output logic                         err,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic                         knn_wr_en,
  output logic                         knn_rd_en,
  output logic                         knn_start,
  output logic                         knn_done,
  output logic [KNN_K_W-1:0]           knn_k,
  output logic [NUM_CH*DATA_WIDTH-1:0] knn_dataValueIn,
  input  logic [KNN_NAME_W-1:0]        knn_dataNameOut,
  input  logic [DATA_WIDTH-1:0]        knn_dataValueOut,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [KNN_NAME_W-1:0]        out_name,
  output logic [DATA_WIDTH-1:0]        out_value,
  output logic                         out_last
`ifdef KNN_SEQ_PERF_EN
  ,
  output logic [31:0]                  perf_cycles
`endif
);

  localparam int DIM_W = (DIMENSIONS > 1) ? $clog2(DIMENSIONS) : 1;

  seq_state_t       state_q, state_d;
  logic [DIM_W-1:0] dim_cnt_q;
  logic [31:0]      vec_cnt_q;
  logic [31:0]      num_train_q;
  logic [31:0]      wait_cnt_q;
  logic [KNN_K_W-1:0] idx_q;

  logic cmd_ok, accept, in_fire, last_beat, wait_last;
  logic cap_wait_done, cap_fire, cap_last_done;

  assign cmd_ok    = (cmd_k != '0) && (cmd_k <= KNN_K_W'(MAX_K));
  assign accept    = (state_q == S_IDLE) && cmd_go && cmd_ok;
  assign in_fire   = in_valid && in_ready;
  // Final query beat: last dimension of vector num_train (training vectors are 0..num_train-1).
  assign last_beat = in_fire && (dim_cnt_q == DIM_W'(DIMENSIONS - 1)) && (vec_cnt_q == num_train_q);
  assign wait_last = (wait_cnt_q == 32'(COMPUTE_CYCLES - 1));

  assign busy      = (state_q != S_IDLE);
  assign in_ready  = (state_q == S_LOAD);
  assign knn_start = (state_q == S_START);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:     if (accept) state_d = S_START;
      S_START:    state_d = S_LOAD;
      S_LOAD:     if (last_beat) state_d = S_DONE;
      S_DONE:     state_d = S_WAIT;
      S_WAIT:     if (wait_last) state_d = S_RD_ISSUE;
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_RD_WAIT:  if (cap_wait_done) state_d = S_RD_OUT;
      S_RD_OUT: begin
        if (cap_last_done)  state_d = S_IDLE;
        else if (cap_fire)  state_d = S_RD_ISSUE;
      end
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      dim_cnt_q       <= '0;
      vec_cnt_q       <= '0;
      num_train_q     <= '0;
      wait_cnt_q      <= '0;
      idx_q           <= '0;
      knn_k           <= '0;
      err             <= 1'b0;
      knn_wr_en       <= 1'b0;
      knn_dataValueIn <= '0;
      knn_done        <= 1'b0;
    end else begin
      state_q   <= state_d;
      err       <= (state_q == S_IDLE) && cmd_go && !cmd_ok;
      knn_wr_en <= in_fire;
      // Registered from DONE so it lands one cycle after the final knn_wr_en.
      knn_done  <= (state_q == S_DONE);
      if (in_fire) knn_dataValueIn <= in_data;

      if (accept) begin
        knn_k       <= cmd_k;
        num_train_q <= cmd_num_train;
        dim_cnt_q   <= '0;
        vec_cnt_q   <= '0;
        idx_q       <= '0;
      end else begin
        if (in_fire) begin
          if (dim_cnt_q == DIM_W'(DIMENSIONS - 1)) begin
            dim_cnt_q <= '0;
            vec_cnt_q <= vec_cnt_q + 32'd1;
          end else begin
            dim_cnt_q <= dim_cnt_q + DIM_W'(1);
          end
        end
        if (cap_fire) idx_q <= idx_q + KNN_K_W'(1);
      end

      wait_cnt_q <= (state_q == S_WAIT) ? wait_cnt_q + 32'd1 : 32'd0;
    end
  end

  knn_rd_capture #(
    .DATA_WIDTH (DATA_WIDTH),
    .RD_LATENCY (RD_LATENCY)
  ) u_rd_capture (
    .clk              (clk),
    .reset            (reset),
    .issue            (state_q == S_RD_ISSUE),
    .idx              (idx_q),
    .k                (knn_k),
    .knn_rd_en        (knn_rd_en),
    .knn_dataNameOut  (knn_dataNameOut),
    .knn_dataValueOut (knn_dataValueOut),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_name         (out_name),
    .out_value        (out_value),
    .out_last         (out_last),
    .wait_done        (cap_wait_done),
    .rsp_fire         (cap_fire),
    .last_done        (cap_last_done)
  );

`ifdef KNN_SEQ_PERF_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_cycles <= '0;
    end else if (accept) begin
      perf_cycles <= '0;
    end else if (busy && (perf_cycles != '1)) begin
      perf_cycles <= perf_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_knn_host_sequencer.sv
// Randomized scoreboard bench for knn_host_sequencer with a behavioural accelerator read model.
// Latency: n/a (testbench).
// Backpressure: random in_valid gaps and out_ready stalls are applied by the stimulus processes.
module tb_knn_host_sequencer;

  localparam int DW   = 32;
  localparam int DIM  = 4;
  localparam int NCH  = 1;
  localparam int MAXK = 16;
  localparam int RDL  = 2;
  localparam int CC   = 8;

  typedef struct packed {
    logic [31:0] name;
    logic [31:0] value;
    logic        last;
  } res_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              cmd_go;
  logic [31:0]       cmd_k;
  logic [31:0]       cmd_num_train;
  logic              busy, err;
  logic              in_valid, in_ready;
  logic [NCH*DW-1:0] in_data;
  logic              knn_wr_en, knn_rd_en, knn_start, knn_done;
  logic [31:0]       knn_k;
  logic [NCH*DW-1:0] knn_dataValueIn;
  logic [31:0]       knn_dataNameOut;
  logic [DW-1:0]     knn_dataValueOut;
  logic              out_valid, out_ready;
  logic [31:0]       out_name;
  logic [DW-1:0]     out_value;
  logic              out_last;
`ifdef KNN_SEQ_PERF_EN
  logic [31:0]       perf_cycles;
`endif

  knn_host_sequencer #(
    .DATA_WIDTH(DW), .DIMENSIONS(DIM), .NUM_CH(NCH), .MAX_K(MAXK),
    .RD_LATENCY(RDL), .COMPUTE_CYCLES(CC)
  ) dut (
    .clk(clk), .reset(reset), .cmd_go(cmd_go), .cmd_k(cmd_k), .cmd_num_train(cmd_num_train),
    .busy(busy), .err(err), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .knn_wr_en(knn_wr_en), .knn_rd_en(knn_rd_en), .knn_start(knn_start), .knn_done(knn_done),
    .knn_k(knn_k), .knn_dataValueIn(knn_dataValueIn), .knn_dataNameOut(knn_dataNameOut),
    .knn_dataValueOut(knn_dataValueOut), .out_valid(out_valid), .out_ready(out_ready),
    .out_name(out_name), .out_value(out_value), .out_last(out_last)
`ifdef KNN_SEQ_PERF_EN
    , .perf_cycles(perf_cycles)
`endif
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int cyc = 0, start_cnt = 0, done_cnt = 0, wr_cnt = 0, err_cnt = 0;
  int last_wr_cyc = -10, idle_cyc = -1;
  int bp_pct = 0;
  logic [NCH*DW-1:0] wq[$];
  res_t exp_q[$];
  res_t acc_q[$];
  logic [31:0] preset_names[$];

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] expv);
    chk_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
  endtask

  // Monitor / scoreboard: samples on the falling edge.
  logic [NCH*DW-1:0] mw;
  res_t              me;
  logic              stall_prev = 1'b0;
  logic [64:0]       held;
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 1'b0;
    end else begin
      cyc++;
      if (knn_start) start_cnt++;
      if (err) err_cnt++;
      if (knn_wr_en) begin
        wr_cnt++;
        last_wr_cyc = cyc;
        if (wq.size() > 0) begin
          mw = wq.pop_front();
          chk("wr_data", knn_dataValueIn, mw);
        end else chk("wr_extra", wq.size(), 1);
      end
      if (knn_done) begin
        done_cnt++;
        chk("done_timing", cyc, last_wr_cyc + 1);
      end
      if (cyc == idle_cyc) chk("busy_fall", busy, 0);
      if (out_valid) begin
        if (stall_prev) chk("out_stable", {out_name, out_value, out_last}, held);
        held = {out_name, out_value, out_last};
        stall_prev = !out_ready;
        if (out_ready) begin
          if (exp_q.size() > 0) begin
            me = exp_q.pop_front();
            chk("res_name", out_name, me.name);
            chk("res_value", out_value, me.value);
            chk("res_last", out_last, me.last);
            if (me.last) idle_cyc = cyc + 1;
          end else chk("res_extra", exp_q.size(), 1);
        end
      end else begin
        stall_prev = 1'b0;
      end
    end
  end

  // Accelerator read model: data valid RDL cycles after knn_rd_en, garbage before that.
  res_t ar;
  initial begin
    knn_dataNameOut  = '0;
    knn_dataValueOut = '0;
    forever begin
      @(negedge clk);
      if (reset && knn_rd_en) begin
        if (acc_q.size() > 0) ar = acc_q.pop_front();
        else ar = '{name: 32'hdead, value: 32'hdead, last: 1'b0};
        @(posedge clk);
        #1 knn_dataNameOut = 32'hbad0bad0; knn_dataValueOut = '1;
        repeat (RDL - 1) @(posedge clk);
        #1 knn_dataNameOut = ar.name; knn_dataValueOut = ar.value;
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1 out_ready = ($urandom_range(99, 0) >= bp_pct);
    end
  end

  task automatic drive_beats(input int nbeats, input int gap_pct);
    int sent = 0;
    int budget = 0;
    while (sent < nbeats && budget < 2000) begin
      in_valid = ($urandom_range(99, 0) >= gap_pct);
      in_data  = $urandom;
      @(negedge clk);
      if (in_valid && in_ready) begin
        wq.push_back(in_data);
        sent++;
      end
      @(posedge clk);
      #1;
      budget++;
    end
    in_valid = 1'b0;
    chk("load_beats", sent, nbeats);
  endtask

  task automatic run_job(input int k, input int nt, input int gap, input int bp,
                         input bit go_in_wait, input int abort_after);
    res_t r;
    int s0, d0, w0, e0, b;
    bp_pct = bp;
    for (int i = 0; i < k; i++) begin
      r.name  = (preset_names.size() > 0) ? preset_names.pop_front() : $urandom;
      r.value = $urandom;
      r.last  = (i == k - 1);
      acc_q.push_back(r);
      exp_q.push_back(r);
    end
    s0 = start_cnt; d0 = done_cnt; w0 = wr_cnt; e0 = err_cnt;
    cmd_go = 1'b1; cmd_k = k; cmd_num_train = nt;
    @(posedge clk);
    #1 cmd_go = 1'b0;
    chk("start_n1", knn_start, 1);
    chk("ready_n1", in_ready, 0);
    chk("busy_n1", busy, 1);
    @(posedge clk);
    #1;
    chk("ready_n2", in_ready, 1);
    chk("knn_k", knn_k, k);
    if (abort_after > 0) begin
      drive_beats(abort_after, 0);
      reset = 1'b0;
      #1;
      chk("abort_outs", {busy, err, in_ready, knn_wr_en, knn_rd_en, knn_start, knn_done,
                         knn_k, knn_dataValueIn, out_valid, out_name, out_value, out_last}, 0);
      wq.delete(); acc_q.delete(); exp_q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 chk("abort_idle", busy, 0);
      return;
    end
    drive_beats((nt + 1) * DIM, gap);
    if (go_in_wait) begin
      repeat (3) @(posedge clk);
      #1 cmd_go = 1'b1; cmd_k = 5; cmd_num_train = 0;
      @(posedge clk);
      #1 cmd_go = 1'b0;
      @(posedge clk);
      #1 chk("wait_go_k", knn_k, k);
    end
    b = 0;
    while (b < 3000) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
      b++;
    end
    @(posedge clk);
    #1;
    chk("exp_drained", exp_q.size(), 0);
    chk("idle_after", busy, 0);
    chk("wr_count", wr_cnt - w0, (nt + 1) * DIM);
    chk("start_count", start_cnt - s0, 1);
    chk("done_count", done_cnt - d0, 1);
    chk("no_err", err_cnt - e0, 0);
  endtask

  task automatic bad_cmd(input int k);
    int s0, e0;
    s0 = start_cnt; e0 = err_cnt;
    cmd_go = 1'b1; cmd_k = k; cmd_num_train = 1;
    @(posedge clk);
    #1 cmd_go = 1'b0;
    chk("bad_busy", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bad_err_pulses", err_cnt - e0, 1);
    chk("bad_no_start", start_cnt - s0, 0);
    chk("bad_busy_late", busy, 0);
  endtask

  initial begin
    reset = 1'b0; cmd_go = 1'b0; cmd_k = 0; cmd_num_train = 0;
    in_valid = 1'b0; in_data = '0;
    #12;
    chk("reset_outs", {busy, err, in_ready, knn_wr_en, knn_rd_en, knn_start, knn_done,
                       knn_k, knn_dataValueIn, out_valid, out_name, out_value, out_last}, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1;

    bad_cmd(0);
    bad_cmd(MAXK + 1);

    preset_names.push_back(32'd7);
    preset_names.push_back(32'd3);
    run_job(2, 2, 0, 0, 1'b0, 0);

    run_job(3, 2, 0, 0, 1'b0, 10);
    run_job(3, 1, 0, 0, 1'b0, 0);

    for (int i = 0; i < 6; i++) begin
      run_job($urandom_range(MAXK, 1), $urandom_range(3, 0), 30, 40, 1'b0, 0);
    end

    run_job(3, 1, 20, 20, 1'b1, 0);
    run_job(2, 0, 0, 0, 1'b0, 0);
    run_job(MAXK, 0, 0, 10, 1'b0, 0);

`ifdef KNN_SEQ_PERF_EN
    run_job(1, 0, 0, 0, 1'b0, 0);
    // START + query beats + DONE + WAIT + (issue + latency + out) per result
    chk("perf_cycles", perf_cycles, 1 + DIM + 1 + CC + (1 + RDL + 1));
    repeat (3) @(posedge clk);
    #1 chk("perf_hold", perf_cycles, 1 + DIM + 1 + CC + (1 + RDL + 1));
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
